// File: rtl/argmax_reader_pkg.sv
// Shared definitions for the argmax reader and the neuron datapath:
// default sizes, FSM state encoding and sign-magnitude field positions.
package argmax_reader_pkg;

  localparam int N_OUT_DEF = 10;
  localparam int W_DEF     = 8;
  localparam int IDX_W_DEF = 4;

  // Sign-magnitude activation layout: sign in the MSB, magnitude below it.
  localparam int SM_SIGN_POS = W_DEF - 1;
  localparam int SM_MAG_MSB  = W_DEF - 2;
  localparam int SM_MAG_LSB  = 0;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/argmax_reader_if.sv
// Activation-in / result-out handshake bundle for the argmax reader.
// master = producer/consumer side, slave = the reader itself.
interface argmax_reader_if
  import argmax_reader_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int IDX_W = IDX_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [W-1:0]     out_value;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_index,
    input  out_value
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_index,
    output out_value
  );

endinterface

// File: rtl/argmax_reader_sm_to_twos.sv
// Sign-magnitude to two's complement converter; both zero encodings map to 0.
module sm_to_twos
  import argmax_reader_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0]        sm,
  output logic signed [W-1:0] tc
);

  logic [W-1:0] mag_ext;

  always_comb begin
    mag_ext = {1'b0, sm[W-2:0]};
    tc      = sm[W-1] ? -$signed(mag_ext) : $signed(mag_ext);
  end

endmodule

// File: rtl/argmax_reader.sv
// Frame-wise argmax over N_OUT sign-magnitude activations; holds index and
// raw value of the largest until the consumer takes it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting beats, tracking running best (in_ready=1)
// HOLD    | frame complete, result presented (out_valid=1, in_ready=0)
module argmax_reader
  import argmax_reader_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int W     = W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  argmax_reader_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [W-1:0]     best_val;
  logic [IDX_W-1:0] best_idx;
  logic             in_ready_q;
  logic             out_valid_q;

  logic signed [W-1:0] cur_tc;
  logic signed [W-1:0] best_tc;
  logic                accept;
  logic                take_new;

  sm_to_twos #(.W(W)) u_cur_conv (
    .sm (bus.in_data),
    .tc (cur_tc)
  );

  sm_to_twos #(.W(W)) u_best_conv (
    .sm (best_val),
    .tc (best_tc)
  );

  always_comb begin
    accept   = bus.in_valid && in_ready_q;
    // Strict greater keeps the earliest index on ties (+0 and -0 included).
    take_new = (cnt == '0) || (cur_tc > best_tc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= COLLECT;
      cnt         <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state       <= COLLECT;
      cnt         <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (take_new) begin
              best_val <= bus.in_data;
              best_idx <= cnt;
            end
            if (cnt == LAST_IDX) begin
              cnt         <= '0;
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= COLLECT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= COLLECT;
          cnt         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = best_idx;
  assign bus.out_value = best_val;

endmodule

// File: tb/tb_argmax_reader.sv
// Directed self-checking bench for argmax_reader.
module tb_argmax_reader;
  import argmax_reader_pkg::*;

  logic clk;
  logic rst;
  logic clr;

  int tests;
  int fails;

  argmax_reader_if #(.W(8), .IDX_W(4)) bus ();

  argmax_reader #(.N_OUT(10), .W(8), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] f_mixed [10] = '{8'h05, 8'h8A, 8'h11, 8'h7F, 8'h00, 8'h3C, 8'h81, 8'h7E, 8'h22, 8'h90};
  logic [7:0] f_negup [10] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89, 8'h8A};
  logic [7:0] f_negdn [10] = '{8'h8A, 8'h89, 8'h88, 8'h87, 8'h86, 8'h85, 8'h84, 8'h83, 8'h82, 8'h81};
  logic [7:0] f_zero  [10] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] f_tie   [10] = '{8'h01, 8'h10, 8'h40, 8'h3F, 8'h00, 8'h85, 8'h20, 8'h40, 8'h0F, 8'hFF};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams one frame at one beat per cycle; the result must not appear early.
  task automatic send_frame(input logic [7:0] f [10], input string tag);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = f[i];
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s beat%0d: in_ready=%b out_valid=%b, required 1/0", tag, i, bus.in_ready, bus.out_valid);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_index !== 4'd0 || bus.out_value !== 8'h00) begin
      fails++;
      $display("FAIL reset_idle: rdy=%b vld=%b idx=%0d val=%h, required 1 0 0 00",
               bus.in_ready, bus.out_valid, bus.out_index, bus.out_value);
    end
  endtask

  task automatic test_mixed_frame();
    send_frame(f_mixed, "mixed");
    tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mixed_latency: vld=%b rdy=%b, required 1/0", bus.out_valid, bus.in_ready);
    end
    tests++;
    if (bus.out_index !== 4'd3 || bus.out_value !== 8'h7F) begin
      fails++;
      $display("FAIL mixed_result: idx=%0d val=%h, required 3 7f", bus.out_index, bus.out_value);
    end
    handshake();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mixed_release: vld=%b rdy=%b, required 0/1", bus.out_valid, bus.in_ready);
    end
    // Immediate back-to-back frame.
    send_frame(f_mixed, "mixed_b2b");
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd3 || bus.out_value !== 8'h7F) begin
      fails++;
      $display("FAIL mixed_b2b: vld=%b idx=%0d val=%h, required 1 3 7f", bus.out_valid, bus.out_index, bus.out_value);
    end
    handshake();
  endtask

  task automatic test_negative();
    send_frame(f_negup, "neg_up");
    tests++;
    if (bus.out_index !== 4'd0 || bus.out_value !== 8'h81) begin
      fails++;
      $display("FAIL neg_up: idx=%0d val=%h, required 0 81", bus.out_index, bus.out_value);
    end
    handshake();
    send_frame(f_negdn, "neg_dn");
    tests++;
    if (bus.out_index !== 4'd9 || bus.out_value !== 8'h81) begin
      fails++;
      $display("FAIL neg_dn: idx=%0d val=%h, required 9 81", bus.out_index, bus.out_value);
    end
    handshake();
  endtask

  task automatic test_ties();
    send_frame(f_zero, "tie_zero");
    tests++;
    if (bus.out_index !== 4'd0 || bus.out_value !== 8'h80) begin
      fails++;
      $display("FAIL tie_zero: idx=%0d val=%h, required 0 80", bus.out_index, bus.out_value);
    end
    handshake();
    send_frame(f_tie, "tie_40");
    tests++;
    if (bus.out_index !== 4'd2 || bus.out_value !== 8'h40) begin
      fails++;
      $display("FAIL tie_40: idx=%0d val=%h, required 2 40", bus.out_index, bus.out_value);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    send_frame(f_mixed, "bp");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h7F;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_index !== 4'd3 || bus.out_value !== 8'h7F) begin
        fails++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b idx=%0d val=%h, required 1 0 3 7f",
                 i, bus.out_valid, bus.in_ready, bus.out_index, bus.out_value);
      end
      tick();
    end
    handshake();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: vld=%b rdy=%b, required 0/1", bus.out_valid, bus.in_ready);
    end
    send_frame(f_negup, "bp_next");
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd0 || bus.out_value !== 8'h81) begin
      fails++;
      $display("FAIL bp_next: vld=%b idx=%0d val=%h, required 1 0 81", bus.out_valid, bus.out_index, bus.out_value);
    end
    handshake();
  endtask

  task automatic test_abort();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h7F;
      tick();
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_index !== 4'd0 || bus.out_value !== 8'h00) begin
      fails++;
      $display("FAIL clr_state: vld=%b rdy=%b idx=%0d val=%h, required 0 1 0 00",
               bus.out_valid, bus.in_ready, bus.out_index, bus.out_value);
    end
    send_frame(f_negdn, "clr_next");
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd9 || bus.out_value !== 8'h81) begin
      fails++;
      $display("FAIL clr_next: vld=%b idx=%0d val=%h, required 1 9 81", bus.out_valid, bus.out_index, bus.out_value);
    end

    // Async reset while holding a result: must clear without a clock edge.
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_index !== 4'd0 || bus.out_value !== 8'h00) begin
      fails++;
      $display("FAIL rst_hold: vld=%b rdy=%b idx=%0d val=%h, required 0 1 0 00",
               bus.out_valid, bus.in_ready, bus.out_index, bus.out_value);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) tick();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_release: vld=%b rdy=%b, required 0/1", bus.out_valid, bus.in_ready);
    end
    send_frame(f_mixed, "rst_next");
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd3 || bus.out_value !== 8'h7F) begin
      fails++;
      $display("FAIL rst_next: vld=%b idx=%0d val=%h, required 1 3 7f", bus.out_valid, bus.out_index, bus.out_value);
    end
    handshake();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_mixed_frame();
    test_negative();
    test_ties();
    test_backpressure();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/argmax_reader.md
# argmax_reader

Consumes the stream of output-layer activations (8-bit sign-magnitude, post-ReLU or raw) one neuron per accepted beat and reports the index and value of the largest one. It is the reader at the far end of the network datapath: the neuron array writes activations, this block turns a frame of `N_OUT` activations into a classification result. Valid/ready on both sides; one frame in flight at a time.

## Interface
- `N_OUT`, 10, activations per frame (number of output neurons), ≥ 2
- `W`, 8, activation width, sign-magnitude: bit `W-1` = sign
- `IDX_W`, 4, index width, ≥ clog2(`N_OUT`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset: asynchronous, active-low
- `clr`  in  1  synchronous frame abort, active-high
- `in_valid`  in  1  activation beat offered
- `in_ready`  out  1  block can accept a beat
- `in_data`  in  `W`  activation, sign-magnitude
- `out_valid`  out  1  result held
- `out_ready`  in  1  consumer takes result
- `out_index`  out  `IDX_W`  position (0-based) of the maximum in the frame
- `out_value`  out  `W`  raw sign-magnitude word of the maximum

## Operation
- Two states:
  - `COLLECT`: `in_ready`=1.
  - `HOLD`: `in_ready`=0, `out_valid`=1.
- A beat is accepted when `in_valid && in_ready`.
- The beat counter `cnt` (0..`N_OUT`-1) increments on each accepted beat.
- Compare rule:
  - Convert each activation to `W`-bit two's complement: magnitude, negated if the sign bit is set. −0 (0x80) maps to 0.
  - Compare signed.
  - Beat 0 always loads best value and index.
  - A later beat replaces the best only if strictly greater. Ties keep the lowest index, and +0/−0 compare equal.
- The stored best value is the raw input word, not the converted one.
- On the accept at `cnt`=`N_OUT`-1:
  - Final compare is applied.
  - Go to `HOLD`; `cnt` returns to 0.
- `HOLD` lasts until `out_valid && out_ready`, then the block returns to `COLLECT`.
- `out_index`/`out_value` are stable throughout `HOLD`. Beats offered in `HOLD` are not accepted.
- `clr` (highest synchronous priority):
  - Forces `COLLECT` and `cnt`=0, and zeroes best value and index.
  - The partial frame or held result is discarded. No beat is accepted in the `clr` cycle.
- `rst` low, at any time including mid-frame or mid-`HOLD`:
  - Immediately forces `COLLECT`, `cnt`=0, best=0, index=0.
  - No result is emitted for the interrupted frame.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_index`=0, `out_value`=0.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready`.
- Throughput in `COLLECT`: one beat per cycle.
- Latency: `out_valid` rises on the clock edge that accepts the last beat, so it is visible the next cycle.
- Minimum frame period: `N_OUT` + 1 cycles. The handoff cycle is a bubble, because `in_ready` is 0 while `out_valid` is 1, including the handshake cycle.
- `out_ready` asserted while `out_valid`=0 has no effect.

## Structure
- Shared package holds:
  - `W`, `N_OUT`, `IDX_W` defaults
  - state encoding `COLLECT`/`HOLD`
  - sign-magnitude field positions, used by the neuron datapath as well
- One sub-module: `sm_to_twos` (`W`-bit sign-magnitude → two's complement, −0 → 0). It is purely combinational and instantiated twice: incoming beat and stored best.
- The rest (counter, best registers, FSM) is inline; roughly 150 lines.

## Test plan
1. Reset, then idle → `in_ready`=1, `out_valid`=0, `out_index`=0, `out_value`=0.
2. Frame {05,8A,11,7F,00,3C,81,7E,22,90} at one beat/cycle → `out_valid` the cycle after beat 9, `out_index`=3, `out_value`=0x7F. Next frame accepted right after the handshake.
3. All-negative frame {81,82,…,8A} (−1…−10) → `out_index`=0, `out_value`=0x81. Frame {8A,…,81} → `out_index`=9, `out_value`=0x81.
4. Ties:
   - {80,00,00,…} → `out_index`=0, `out_value`=0x80 (+0 does not beat −0).
   - 0x40 at indices 2 and 7, all others smaller → `out_index`=2.
5. Backpressure: `out_ready`=0 for 5 cycles after result, `in_valid`=1 with data 0x7F throughout → `out_valid` and outputs stable, no beat counted, `in_ready`=0. Then `out_ready`=1 → one handshake, and the following frame's result ignores the held-off data.
6. Aborts:
   - `clr` after 4 accepted beats, then a full new frame → result reflects only the new frame.
   - `rst` pulsed low mid-`HOLD` → outputs zero immediately, `in_ready`=1, no stale result after release.
